// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage FSM states and control-field layout.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int WB_W          = 2;
  localparam int MEM_W         = 2;
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 0;

  localparam logic [WB_W-1:0] BUBBLE_WB = 2'b00;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles of a bus access; saturates at TIMEOUT and flags the last/terminal counts.
module mem_timeout_counter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !tc)
      cnt <= cnt + CNT_W'(1);
  end

  // last: the count reaches TIMEOUT on the coming edge if no ack arrives
  assign last = (cnt == CNT_W'(TIMEOUT - 1));
  assign tc   = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: handshaked data-memory access with upstream stall, bubble insertion,
// misalignment and timeout abort.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MEM_W-1:0]  MEMin,
  input  logic [WB_W-1:0]   WBin,
  input  logic [31:0]       ADDin,
  input  logic [31:0]       WDin,
  input  logic [4:0]        Rdin,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              err,
  output logic [WB_W-1:0]   WBout,
  output logic [31:0]       ADDout,
  output logic [31:0]       DMout,
  output logic [4:0]        Rdout
);

  mem_state_e state, state_nxt;

  logic [WB_W-1:0] wb_p1;
  logic [4:0]      rd_p1;
  logic [31:0]     dm_p1;
  logic            memop, misal, issue, ack_hit, cnt_last, cnt_tc;

  assign memop   = |MEMin;
  assign misal   = |ADDin[1:0];
  assign issue   = (state == IDLE) && memop && !misal;
  // once the terminal count is reached mem_req is already low, so a late ack is ignored
  assign ack_hit = (state == BUSY) && !cnt_tc && mem_ack;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (issue),
    .en   (state == BUSY),
    .last (cnt_last),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_p1     <= '0;
      rd_p1     <= '0;
      dm_p1     <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= (MEMin == 2'b01);
        mem_addr  <= ADDin;
        mem_wdata <= WDin;
        wb_p1     <= WBin;
        rd_p1     <= Rdin;
      end else if ((state == BUSY) && (mem_ack || cnt_last)) begin
        mem_req <= 1'b0;
      end
      if (ack_hit)
        dm_p1 <= mem_we ? 32'd0 : mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY: begin
        if (cnt_tc)
          state_nxt = IDLE;
        else if (mem_ack)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    WBout  = BUBBLE_WB;
    ADDout = ADDin;
    Rdout  = Rdin;
    DMout  = 32'd0;
    stall  = 1'b0;
    err    = 1'b0;
    case (state)
      IDLE: begin
        if (!memop)
          WBout = WBin;
        else if (misal)
          err = 1'b1;
        else
          stall = 1'b1;
      end
      BUSY: begin
        ADDout = mem_addr;
        Rdout  = rd_p1;
        if (cnt_tc)
          err = 1'b1;
        else
          stall = 1'b1;
      end
      DONE: begin
        WBout  = wb_p1;
        ADDout = mem_addr;
        Rdout  = rd_p1;
        DMout  = dm_p1;
      end
      default: ;
    endcase
    if (!rst) begin
      WBout = BUBBLE_WB;
      err   = 1'b0;
    end
  end

endmodule
